// File: rtl/song_sequencer.sv
// Playlist controller: sequences start / pause / skip / auto-advance with a silent gap between songs.
// Latency: outputs are Moore-decoded from registered state; play button to reader_reset 1 cycle, to play 2 cycles.
// Backpressure: none; button pulses are consumed on the edge they arrive, ignored where they have no meaning.
// Optional feature: define SONG_SEQ_REPEAT_EN to loop the playlist instead of stopping after the last song.
module song_sequencer #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reader_reset,
  output logic              player_enable,
  output logic              playing
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_START   = 3'd1,
    ST_PLAYING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              advance;

  // State, song index and gap counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STOPPED;
      song_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      song_q    <= song_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next state: button/done decoding, then the shared advance action overrides the target
  always_comb begin
    state_d   = state_q;
    song_d    = song_q;
    gap_cnt_d = gap_cnt_q;
    advance   = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        if (play_button) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_PLAYING;
      end
      ST_PLAYING: begin
        // next wins over done so a simultaneous pair advances once with no gap
        if (next_button) begin
          advance = 1'b1;
        end else if (song_done) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (next_button) begin
          advance = 1'b1;
        end else if (play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_GAP: begin
        if (next_button || (gap_cnt_q == '0)) begin
          advance = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STOPPED;
        song_d  = '0;
      end
    endcase

    if (advance) begin
      gap_cnt_d = '0;
      if (song_q >= LAST_SONG) begin
        song_d = '0;
`ifdef SONG_SEQ_REPEAT_EN
        state_d = ST_START;
`else
        state_d = ST_STOPPED;
`endif
      end else begin
        song_d  = song_q + SONG_W'(1);
        state_d = ST_START;
      end
    end
  end

  // Moore output decode from registered state
  always_comb begin
    play          = 1'b0;
    reader_reset  = 1'b0;
    player_enable = 1'b0;
    playing       = 1'b0;
    case (state_q)
      ST_START:   reader_reset = 1'b1;
      ST_PLAYING: begin
        play          = 1'b1;
        player_enable = 1'b1;
        playing       = 1'b1;
      end
      ST_PAUSED:  play = 1'b1;
      default:    ;
    endcase
  end

  assign song = song_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random button/done traffic against a reference model.
// Latency: model expectations are compared every cycle on the falling edge.
// Backpressure: not applicable.
module tb_song_sequencer;

  localparam int NUM_SONGS  = 4;
  localparam int SONG_W     = 2;
  localparam int GAP_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              play_button, next_button, song_done;
  logic              play, reader_reset, player_enable, playing;
  logic [SONG_W-1:0] song;

  int n_checks = 0;
  int n_pass   = 0;

  song_sequencer #(
    .NUM_SONGS  (NUM_SONGS),
    .SONG_W     (SONG_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .play_button   (play_button),
    .next_button   (next_button),
    .song_done     (song_done),
    .play          (play),
    .song          (song),
    .reader_reset  (reader_reset),
    .player_enable (player_enable),
    .playing       (playing)
  );

  always #5 clk = ~clk;

  // Reference model: what the listener experiences, tracked as a mode plus song and silence left
  typedef enum {M_IDLE, M_RESTART, M_RUN, M_HOLD, M_SILENT} mode_t;
  mode_t m_mode;
  int    m_song;
  int    m_silent_left;

  // Last sampled DUT outputs
  logic              s_play, s_en, s_rr, s_playing;
  logic [SONG_W-1:0] s_song;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] exp_vec();
    logic p, e, r, g;
    logic [1:0] s;
    p = (m_mode == M_RUN) || (m_mode == M_HOLD);
    e = (m_mode == M_RUN);
    r = (m_mode == M_RESTART);
    g = (m_mode == M_RUN);
    s = 2'(m_song);
    return {26'd0, p, e, r, g, s};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {26'd0, play, player_enable, reader_reset, playing, song};
  endfunction

  task automatic model_reset();
    m_mode        = M_IDLE;
    m_song        = 0;
    m_silent_left = 0;
  endtask

  task automatic model_advance();
    m_song = (m_song + 1) % NUM_SONGS;
    if (m_song == 0) begin
`ifdef SONG_SEQ_REPEAT_EN
      m_mode = M_RESTART;
`else
      m_mode = M_IDLE;
`endif
    end else begin
      m_mode = M_RESTART;
    end
  endtask

  task automatic model_step(input logic p, input logic n, input logic d);
    case (m_mode)
      M_IDLE:    if (p) m_mode = M_RESTART;
      M_RESTART: m_mode = M_RUN;
      M_RUN: begin
        if (n) model_advance();
        else if (d) begin
          m_mode        = M_SILENT;
          m_silent_left = GAP_CYCLES;
        end else if (p) m_mode = M_HOLD;
      end
      M_HOLD: begin
        if (n) model_advance();
        else if (p) m_mode = M_RUN;
      end
      M_SILENT: begin
        m_silent_left--;
        if (n || m_silent_left == 0) model_advance();
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock cycle: sample and check on the falling edge, apply inputs, let the model follow the rising edge
  task automatic drive(input logic p, input logic n, input logic d);
    @(negedge clk);
    s_play    = play;
    s_en      = player_enable;
    s_rr      = reader_reset;
    s_playing = playing;
    s_song    = song;
    check("outputs", obs_vec(), exp_vec());
    play_button = p;
    next_button = n;
    song_done   = d;
    @(posedge clk);
    model_step(p, n, d);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately
  task automatic async_reset();
    #2;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    reset_n     = 1'b0;
    #1;
    model_reset();
    check("reset_now", obs_vec(), 32'd0);
    @(negedge clk);
    check("reset_hold", obs_vec(), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int silent;
    bit seen_rr;

    reset_n     = 1'b0;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", obs_vec(), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Start from stop: one restart cycle, then playing song 0
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("start_rr", {31'd0, s_rr}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("start_play", {28'd0, s_play, s_en, s_playing, s_rr}, 32'b1110);

    // Skip to song 1, then let it finish and measure the silent gap
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1);
    silent  = 0;
    seen_rr = 1'b0;
    for (int k = 0; k < 20 && !seen_rr; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (s_rr) seen_rr = 1'b1;
      else if (!s_play) silent++;
    end
    check("gap_len", 32'(silent), 32'(GAP_CYCLES));
    check("gap_next_song", {30'd0, s_song}, 32'd2);
    drive(1'b0, 1'b0, 1'b0);
    check("gap_resume", {31'd0, s_play}, 32'd1);

    // Pause, hold song_done while paused, resume
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    check("paused", {29'd0, s_play, s_en, s_playing}, 32'b100);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("resumed", {31'd0, s_en}, 32'd1);

    // Next and done together on song 1: single advance, no gap
    async_reset();
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("next_done_song", {30'd0, s_song}, 32'd2);
    check("next_done_rr", {31'd0, s_rr}, 32'd1);

    // Last song finishing: stop (or wrap when looping)
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1);
    idle(GAP_CYCLES + 4);
    check("after_last_song", {30'd0, s_song}, 32'd0);

    // Reset while in the gap
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    async_reset();
    idle(2);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
